// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the combinational instruction memory and
// queues {pc, word} pairs in a small in-order buffer for decode (valid/ready).
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]      pc_reg, pc_next;
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [31:0]      instr_mem [DEPTH];
   logic [31:0]      pc_mem    [DEPTH];
   logic             buf_nonempty;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign buf_nonempty = (count_reg != '0);
   assign if_valid     = buf_nonempty & ~branch_taken;
   assign pop          = if_valid & if_ready & ~branch_taken;
   // A full buffer can still accept a word when the head leaves in the same cycle.
   assign push         = ~branch_taken & ~freeze & ((count_reg < FULL_CNT) | pop);
   assign imem_addr    = pc_reg;

   always_comb begin
      pc_next    = pc_reg;
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (branch_taken) begin
         pc_next    = branch_addr & ~32'h0000_0003;
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (push) begin
            pc_next   = pc_reg + 32'd4;
            tail_next = ptr_inc(tail_reg);
         end
         if (pop) begin
            head_next = ptr_inc(head_reg);
         end
         if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
         end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg    <= RESET_PC;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         pc_reg    <= pc_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Storage needs no reset: every read is masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[tail_reg] <= imem_rdata;
         pc_mem[tail_reg]    <= pc_reg;
      end
   end

   assign if_instr    = buf_nonempty ? instr_mem[head_reg] : '0;
   assign if_pc       = buf_nonempty ? pc_mem[head_reg] : '0;
   assign if_pc_plus4 = buf_nonempty ? (pc_mem[head_reg] + 32'd4) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, freeze, branch
// redirect and PC wrap / asynchronous reset on a second instance.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n, rst_n_b;
   logic        freeze, branch_taken, if_ready;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4;
   logic        if_valid;
   logic [31:0] imem_addr_b, imem_rdata_b, if_instr_b, if_pc_b, if_pc_plus4_b;
   logic        if_valid_b;
   int          errors = 0;
   int          checks = 0;

   // Memory model: word at address a is 32'h1000_0000 + a.
   assign imem_rdata   = 32'h1000_0000 + imem_addr;
   assign imem_rdata_b = 32'h1000_0000 + imem_addr_b;

   instr_fetch_unit #(.RESET_PC(32'd0), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
      .if_valid(if_valid_b), .if_ready(if_ready), .if_instr(if_instr_b),
      .if_pc(if_pc_b), .if_pc_plus4(if_pc_plus4_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string name, input logic v, input logic [31:0] pc);
      logic [31:0] exp_instr, exp_p4;
      exp_instr = v ? (32'h1000_0000 + pc) : 32'd0;
      exp_p4    = v ? (pc + 32'd4) : 32'd0;
      checks++;
      if (if_valid !== v || if_pc !== pc || if_instr !== exp_instr || if_pc_plus4 !== exp_p4) begin
         errors++;
         $display("FAIL %s: got valid=%b pc=%h instr=%h p4=%h, expected valid=%b pc=%h instr=%h p4=%h",
                  name, if_valid, if_pc, if_instr, if_pc_plus4, v, pc, exp_instr, exp_p4);
      end else begin
         $display("ok   %s: valid=%b pc=%h instr=%h", name, if_valid, if_pc, if_instr);
      end
   endtask

   task automatic chk_addr(input string name, input logic [31:0] exp);
      checks++;
      if (imem_addr !== exp) begin
         errors++;
         $display("FAIL %s: imem_addr=%h expected %h", name, imem_addr, exp);
      end else begin
         $display("ok   %s: imem_addr=%h", name, imem_addr);
      end
   endtask

   task automatic reset_a();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      if_ready = 1'b1;
      freeze = 1'b0;
      branch_taken = 1'b0;
      branch_addr = 32'd0;
      tick();
      tick();
      chk_head("reset_outputs", 1'b0, 32'd0);
      chk_addr("reset_addr", 32'd0);
      rst_n = 1'b1;
      chk_head("after_release_no_edge", 1'b0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_head($sformatf("stream_%0d", k), 1'b1, 32'(4 * k));
      end
   endtask

   task automatic test_backpressure();
      if_ready = 1'b0;
      reset_a();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_head($sformatf("bp_hold_%0d", k), 1'b1, 32'd0);
      end
      chk_addr("bp_addr_stall", 32'd8);
      if_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_head($sformatf("bp_drain_%0d", k), 1'b1, 32'(4 * k));
      end
   endtask

   task automatic test_freeze();
      // Head is 16 with 20 queued and pc at 24.
      freeze = 1'b1;
      tick();
      chk_head("frz_drain_0", 1'b1, 32'd20);
      chk_addr("frz_addr_0", 32'd24);
      tick();
      chk_head("frz_empty", 1'b0, 32'd0);
      tick();
      chk_head("frz_still_empty", 1'b0, 32'd0);
      chk_addr("frz_addr_hold", 32'd24);
      freeze = 1'b0;
      tick();
      chk_head("frz_resume", 1'b1, 32'd24);
      tick();
      chk_head("frz_resume_next", 1'b1, 32'd28);
   endtask

   task automatic test_branch();
      if_ready = 1'b0;
      tick();
      chk_head("br_fill", 1'b1, 32'd28);
      if_ready = 1'b1;
      branch_taken = 1'b1;
      branch_addr = 32'h0000_0043;
      #1;
      checks++;
      if (if_valid !== 1'b0) begin
         errors++;
         $display("FAIL br_valid_masked: if_valid=%b expected 0", if_valid);
      end else begin
         $display("ok   br_valid_masked: if_valid=0");
      end
      tick();
      branch_taken = 1'b0;
      chk_addr("br_target_addr", 32'h0000_0040);
      chk_head("br_flushed", 1'b0, 32'd0);
      tick();
      chk_head("br_first_target", 1'b1, 32'h0000_0040);
   endtask

   task automatic test_branch_freeze();
      branch_taken = 1'b1;
      freeze = 1'b1;
      branch_addr = 32'h0000_0100;
      tick();
      branch_taken = 1'b0;
      chk_addr("bf_target_addr", 32'h0000_0100);
      chk_head("bf_flushed", 1'b0, 32'd0);
      tick();
      chk_head("bf_no_push", 1'b0, 32'd0);
      chk_addr("bf_addr_hold", 32'h0000_0100);
      freeze = 1'b0;
      tick();
      chk_head("bf_resume", 1'b1, 32'h0000_0100);
   endtask

   task automatic test_wrap_async_reset();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8;
      exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000;
      checks++;
      if (imem_addr_b !== 32'hFFFF_FFF8 || if_valid_b !== 1'b0) begin
         errors++;
         $display("FAIL wrap_reset_state: addr=%h valid=%b expected addr=fffffff8 valid=0",
                  imem_addr_b, if_valid_b);
      end else begin
         $display("ok   wrap_reset_state: addr=%h", imem_addr_b);
      end
      rst_n_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (if_valid_b !== 1'b1 || if_pc_b !== exp_pc[k] ||
             if_instr_b !== 32'h1000_0000 + exp_pc[k] || if_pc_plus4_b !== exp_pc[k] + 32'd4) begin
            errors++;
            $display("FAIL wrap_%0d: got valid=%b pc=%h instr=%h p4=%h, expected pc=%h instr=%h p4=%h",
                     k, if_valid_b, if_pc_b, if_instr_b, if_pc_plus4_b, exp_pc[k],
                     32'h1000_0000 + exp_pc[k], exp_pc[k] + 32'd4);
         end else begin
            $display("ok   wrap_%0d: pc=%h instr=%h p4=%h", k, if_pc_b, if_instr_b, if_pc_plus4_b);
         end
      end
      #2;
      rst_n_b = 1'b0;
      #1;
      checks++;
      if (if_valid_b !== 1'b0 || imem_addr_b !== 32'hFFFF_FFF8 || if_pc_b !== 32'd0 || if_instr_b !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: valid=%b addr=%h pc=%h instr=%h expected 0/fffffff8/0/0",
                  if_valid_b, imem_addr_b, if_pc_b, if_instr_b);
      end else begin
         $display("ok   async_reset: valid=0 addr=%h", imem_addr_b);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rst_n_b = 1'b0;
      freeze = 1'b0;
      branch_taken = 1'b0;
      branch_addr = 32'd0;
      if_ready = 1'b1;
      test_reset();
      test_backpressure();
      test_freeze();
      test_branch();
      test_branch_freeze();
      test_wrap_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch initiator. Owns the program counter and drives addresses into the combinational instruction memory, which returns read data in the same cycle.
- Captures each returned word with its PC into a small in-order buffer and presents it to decode with a valid/ready handshake.
- Supports pipeline freeze and branch redirect with buffer flush. Sits between the hazard/branch logic and the IF/ID boundary.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, instruction buffer entries; legal values 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- freeze  input  1  hazard stall; inhibits new fetches
- branch_taken  input  1  redirect request from EX
- branch_addr  input  32  redirect target
- imem_addr  output  32  address to instruction memory; equals current PC
- imem_rdata  input  32  instruction word for imem_addr, same cycle
- if_valid  output  1  buffer head holds a valid instruction
- if_ready  input  1  decode accepts head this cycle
- if_instr  output  32  head instruction; 0 when buffer empty
- if_pc  output  32  PC of head instruction; 0 when buffer empty
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32; 0 when buffer empty

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While rst_n=0:
  - pc = RESET_PC, count = 0, buffer pointers = 0
  - if_valid = 0, if_instr/if_pc/if_pc_plus4 = 0
  - imem_addr = RESET_PC
- Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.
- imem_addr = pc, combinationally, at all times.
- pop = if_valid & if_ready & ~branch_taken.
- push = ~branch_taken & ~freeze & (count < DEPTH | pop).
  - Full buffer plus a same-cycle pop permits a push.
  - count is unchanged when push and pop occur together.
- On push: write {pc, imem_rdata} at the tail; pc <= pc + 4, wrapping 32'hFFFFFFFC -> 32'h0.
- On pop: advance the head.
- Latency: a word fetched at edge N is visible on if_instr after edge N.
  - With if_ready held at 1 and no freeze, throughput is 1 instruction/cycle.
- Freeze: pc and the buffer tail hold. Pops continue, so decode may drain the buffer while frozen.
- Branch (highest priority, overrides freeze):
  - if_valid is forced to 0 combinationally during the branch_taken cycle; no pop occurs.
  - At the next edge: count <= 0, pointers <= 0, pc <= {branch_addr[31:2], 2'b00}.
  - The first instruction from the target appears one cycle after the redirect edge.
- Misaligned branch_addr: low 2 bits are silently cleared.
- if_valid = (count != 0) & ~branch_taken.
- if_instr/if_pc are driven from buffer storage (registered) and are 0 when count = 0.
- Handshake rules:
  - If if_valid=1 and if_ready=0, the head and its outputs hold stable until it is popped or flushed.
  - if_ready while if_valid=0 has no effect.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- No internal state machine beyond pc/count/pointers. Two implicit modes: FETCH (push possible) and FULL/FROZEN (pc hold).

Test Plan:
- Reset with RESET_PC=0, memory returning 32'h1000_0000+addr, if_ready=1 -> if_valid rises one cycle after reset release. if_pc sequence is 0,4,8,... with if_instr=32'h1000_0000, 32'h1000_0004, ... each cycle.
- if_ready=0 for 5 cycles from start -> buffer fills to DEPTH=2 (if_pc=0 held), imem_addr stalls at 8. Then if_ready=1 -> outputs 0,4,8,12 with no gaps or duplicates.
- freeze=1 for 3 cycles while if_ready=1 -> two buffered words drain, if_valid drops, imem_addr holds. Release -> fetch resumes at the held PC with no skipped address.
- branch_taken=1 with branch_addr=32'h0000_0043 while buffer holds 2 entries and if_ready=1 -> if_valid=0 that cycle, no pop. Next cycle imem_addr=32'h40, buffer empty. Following cycle if_pc=32'h40.
- branch_taken and freeze both high -> redirect still occurs. pc=branch target; no push until freeze drops.
- RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFFFFF8, FFFFFFFC, 00000000. Then assert rst_n=0 mid-stream -> if_valid=0 immediately and imem_addr=FFFFFFF8 without a clock edge.
